// File: rtl/roberto_uc.sv
// roberto_uc: round sequencer for the three-sensor distance datapath (measure, send 12 chars, wait 1 s).
// Define ROBERTO_UC_TIMEOUT_EN to build the measurement timeout counter and erro_medida.
module roberto_uc #(
    parameter int unsigned TIMEOUT_CICLOS = 5_000_000,
    parameter int unsigned N_TIMEOUT      = 23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida1,
    input  logic       pronto_medida2,
    input  logic       pronto_medida3,
    input  logic       pronto_serial,
    input  logic       pronto_seg,
    output logic       zera_sensor,
    output logic       zera_serial,
    output logic       zera_seg,
    output logic       medir,
    output logic       cont_seg,
    output logic       partida_tx,
    output logic [1:0] sel_digito,
    output logic [1:0] sel_sensor,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL       = 3'd0,
        PREPARACAO    = 3'd1,
        MEDIDA        = 3'd2,
        ESPERA_MEDIDA = 3'd3,
        TRANSMITE     = 3'd4,
        ESPERA_TX     = 3'd5,
        PROXIMO       = 3'd6,
        ESPERA_SEG    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_digito_q, sel_digito_d;
    logic [1:0] sel_sensor_q, sel_sensor_d;
    logic [2:0] done_q, done_d;
    logic       zera_sensor_q, zera_sensor_d;
    logic       zera_serial_q, zera_serial_d;
    logic       zera_seg_q, zera_seg_d;
    logic       medir_q, medir_d;
    logic       cont_seg_q, cont_seg_d;
    logic       partida_tx_q, partida_tx_d;
    logic       pronto_q, pronto_d;
    logic       all_done_c;
    logic       timeout_c;
    logic       ultimo_c;

    if (64'(TIMEOUT_CICLOS) >= (64'd1 << N_TIMEOUT)) begin : g_bad_timeout_width
        $error("roberto_uc: N_TIMEOUT too narrow for TIMEOUT_CICLOS");
    end

    // Completion looks through the latches so a pulse counts in the cycle it arrives.
    assign all_done_c = &(done_q | {pronto_medida3, pronto_medida2, pronto_medida1});
    assign ultimo_c   = (sel_sensor_q == 2'd1) && (sel_digito_q == 2'd0);

`ifdef ROBERTO_UC_TIMEOUT_EN
    localparam logic [N_TIMEOUT-1:0] TIMEOUT_MAX = N_TIMEOUT'(TIMEOUT_CICLOS - 1);

    logic [N_TIMEOUT-1:0] cnt_q, cnt_d;
    logic                 erro_q, erro_d;

    // Completion has priority over timeout when both land on the same edge.
    always_comb begin
        cnt_d     = cnt_q;
        erro_d    = erro_q;
        timeout_c = 1'b0;
        if (state_q == MEDIDA) begin
            cnt_d  = '0;
            erro_d = 1'b0;
        end else if (state_q == ESPERA_MEDIDA) begin
            if (cnt_q == TIMEOUT_MAX) begin
                timeout_c = 1'b1;
                if (!all_done_c) erro_d = 1'b1;
            end else begin
                cnt_d = cnt_q + N_TIMEOUT'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            erro_q <= erro_d;
        end
    end

    assign erro_medida = erro_q;
`else
    assign timeout_c   = 1'b0;
    assign erro_medida = 1'b0;
`endif

    // Next state, datapath selects, and Moore outputs decoded from the upcoming state.
    always_comb begin
        state_d      = state_q;
        sel_digito_d = sel_digito_q;
        sel_sensor_d = sel_sensor_q;
        done_d       = done_q;

        case (state_q)
            INICIAL:       if (ligar) state_d = PREPARACAO;
            PREPARACAO:    state_d = MEDIDA;
            MEDIDA: begin
                done_d  = 3'b000;
                state_d = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                done_d = done_q | {pronto_medida3, pronto_medida2, pronto_medida1};
                if (all_done_c || timeout_c) state_d = TRANSMITE;
            end
            TRANSMITE:     state_d = ESPERA_TX;
            ESPERA_TX:     if (pronto_serial) state_d = PROXIMO;
            PROXIMO: begin
                if (ultimo_c) begin
                    state_d = ESPERA_SEG;
                end else begin
                    if (sel_digito_q == 2'd0) begin
                        sel_digito_d = 2'd3;
                        sel_sensor_d = sel_sensor_q - 2'd1;
                    end else begin
                        sel_digito_d = sel_digito_q - 2'd1;
                    end
                    state_d = TRANSMITE;
                end
            end
            ESPERA_SEG:    if (pronto_seg) state_d = ligar ? MEDIDA : INICIAL;
            default:       state_d = INICIAL;
        endcase

        if (state_d == INICIAL || state_d == MEDIDA) begin
            sel_digito_d = 2'd3;
            sel_sensor_d = 2'd3;
        end

        zera_sensor_d = (state_d == PREPARACAO);
        zera_serial_d = (state_d == PREPARACAO);
        zera_seg_d    = (state_d == PREPARACAO) || (state_d == MEDIDA);
        medir_d       = (state_d == MEDIDA);
        cont_seg_d    = (state_d == ESPERA_SEG);
        partida_tx_d  = (state_d == TRANSMITE);
        pronto_d      = (state_d == PROXIMO) && ultimo_c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= INICIAL;
            sel_digito_q  <= 2'd3;
            sel_sensor_q  <= 2'd3;
            done_q        <= 3'b000;
            zera_sensor_q <= 1'b0;
            zera_serial_q <= 1'b0;
            zera_seg_q    <= 1'b0;
            medir_q       <= 1'b0;
            cont_seg_q    <= 1'b0;
            partida_tx_q  <= 1'b0;
            pronto_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_digito_q  <= sel_digito_d;
            sel_sensor_q  <= sel_sensor_d;
            done_q        <= done_d;
            zera_sensor_q <= zera_sensor_d;
            zera_serial_q <= zera_serial_d;
            zera_seg_q    <= zera_seg_d;
            medir_q       <= medir_d;
            cont_seg_q    <= cont_seg_d;
            partida_tx_q  <= partida_tx_d;
            pronto_q      <= pronto_d;
        end
    end

    assign zera_sensor = zera_sensor_q;
    assign zera_serial = zera_serial_q;
    assign zera_seg    = zera_seg_q;
    assign medir       = medir_q;
    assign cont_seg    = cont_seg_q;
    assign partida_tx  = partida_tx_q;
    assign pronto      = pronto_q;
    assign sel_digito  = sel_digito_q;
    assign sel_sensor  = sel_sensor_q;
    assign db_estado   = {1'b0, state_q};

endmodule

// File: tb/tb_roberto_uc.sv
// Bench for roberto_uc: randomized rounds checked against a cycle-level model of the round protocol.
module tb_roberto_uc;

    localparam int T      = 100;
    localparam int NT     = 7;
    localparam int BUDGET = T + 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       pronto_medida1 = 1'b0;
    logic       pronto_medida2 = 1'b0;
    logic       pronto_medida3 = 1'b0;
    logic       pronto_serial = 1'b0;
    logic       pronto_seg = 1'b0;
    logic       zera_sensor, zera_serial, zera_seg, medir, cont_seg, partida_tx;
    logic       pronto, erro_medida;
    logic [1:0] sel_digito, sel_sensor;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    roberto_uc #(.TIMEOUT_CICLOS(T), .N_TIMEOUT(NT)) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_medida1(pronto_medida1), .pronto_medida2(pronto_medida2),
        .pronto_medida3(pronto_medida3), .pronto_serial(pronto_serial),
        .pronto_seg(pronto_seg), .zera_sensor(zera_sensor), .zera_serial(zera_serial),
        .zera_seg(zera_seg), .medir(medir), .cont_seg(cont_seg), .partida_tx(partida_tx),
        .sel_digito(sel_digito), .sel_sensor(sel_sensor), .pronto(pronto),
        .erro_medida(erro_medida), .db_estado(db_estado)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Character ch of a round: sensors 1..3 map to select 3..1, digits D3,D2,D1,'#' to 3..0.
    function automatic logic [3:0] exp_pair(input int ch);
        return {2'(3 - ch / 4), 2'(3 - ch % 4)};
    endfunction

    function automatic logic [31:0] pulses();
        return 32'({zera_sensor, zera_serial, zera_seg, medir, cont_seg, partida_tx, pronto, erro_medida});
    endfunction

    task automatic start_run();
        ligar = 1'b1;
        @(negedge clock);
        check("prep_state", 32'(db_estado), 1);
        check("prep_clears", 32'({zera_sensor, zera_serial, zera_seg, medir}), 32'h0000_000E);
        @(negedge clock);
        check("medida_state", 32'(db_estado), 2);
        check("medida_out", 32'({medir, zera_seg, zera_sensor, zera_serial}), 32'h0000_000C);
        check("medida_sel", 32'({sel_sensor, sel_digito}), 32'h0000_000F);
        @(negedge clock);
        check("wait_state", 32'(db_estado), 3);
        check("medir_width", 32'(medir), 0);
    endtask

    task automatic enter_wait();
        @(negedge clock);
        check("wait_state_rep", 32'(db_estado), 3);
        check("medir_width_rep", 32'(medir), 0);
    endtask

    // Runs one round from espera_medida; delay -1 means that sensor never answers.
    task automatic do_round(input int d1, input int d2, input int d3, input int stop_ch, input int sd_fix);
        int  c;
        int  maxd;
        int  exp_t;
        int  sd;
        bit  all;
        bit  exp_err;
        all  = (d1 >= 0) && (d2 >= 0) && (d3 >= 0);
        maxd = d1;
        if (d2 > maxd) maxd = d2;
        if (d3 > maxd) maxd = d3;
`ifdef ROBERTO_UC_TIMEOUT_EN
        if (all && (maxd + 1 <= T)) begin
            exp_t = maxd + 1; exp_err = 1'b0;
        end else begin
            exp_t = T;        exp_err = 1'b1;
        end
`else
        exp_t   = all ? maxd + 1 : -1;
        exp_err = 1'b0;
`endif
        c = 0;
        forever begin
            pronto_medida1 = (d1 == c);
            pronto_medida2 = (d2 == c);
            pronto_medida3 = (d3 == c);
            @(negedge clock);
            c++;
            if (db_estado != 4'd3 || c >= BUDGET) break;
        end
        pronto_medida1 = 1'b0; pronto_medida2 = 1'b0; pronto_medida3 = 1'b0;
        if (exp_t < 0) begin
            check("no_timeout_hold", 32'(db_estado), 3);
            check("no_timeout_cycles", 32'(c), 32'(BUDGET));
            return;
        end
        check("meas_latency", 32'(c), 32'(exp_t));
        check("tx_state", 32'(db_estado), 4);
        check("tx_start", 32'(partida_tx), 1);
        check("erro_flag", 32'(erro_medida), 32'(exp_err));
        for (int ch = 0; ch < 12; ch++) begin
            check("tx_pair", 32'({sel_sensor, sel_digito}), 32'(exp_pair(ch)));
            if (ch == stop_ch) ligar = 1'b0;
            sd = (sd_fix > 0) ? sd_fix : int'($urandom_range(1, 6));
            repeat (sd) @(negedge clock);
            check("espera_tx_state", 32'(db_estado), 5);
            check("tx_width", 32'(partida_tx), 0);
            check("sel_hold", 32'({sel_sensor, sel_digito}), 32'(exp_pair(ch)));
            pronto_serial = 1'b1;
            @(negedge clock);
            pronto_serial = 1'b0;
            check("proximo_state", 32'(db_estado), 6);
            check("pronto_pulse", 32'(pronto), (ch == 11) ? 1 : 0);
            @(negedge clock);
            if (ch < 11) begin
                check("next_tx_state", 32'(db_estado), 4);
                check("next_tx_start", 32'(partida_tx), 1);
            end else begin
                check("espera_seg_state", 32'(db_estado), 7);
                check("cont_seg_on", 32'(cont_seg), 1);
                check("pronto_width", 32'(pronto), 0);
                check("erro_sticky", 32'(erro_medida), 32'(exp_err));
            end
        end
        repeat ($urandom_range(0, 3)) @(negedge clock);
        check("cont_seg_hold", 32'({cont_seg, partida_tx}), 32'h0000_0002);
        pronto_seg = 1'b1;
        @(negedge clock);
        pronto_seg = 1'b0;
        if (ligar) begin
            check("restart_state", 32'(db_estado), 2);
            check("restart_medir", 32'(medir), 1);
        end else begin
            check("stop_state", 32'(db_estado), 0);
            check("stop_outputs", pulses() & 32'h0000_00FE, 0);
        end
        check("round_end_sel", 32'({sel_sensor, sel_digito}), 32'h0000_000F);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int stop;
        repeat (3) @(negedge clock);
        check("reset_state", 32'(db_estado), 0);
        check("reset_sel", 32'({sel_sensor, sel_digito}), 32'h0000_000F);
        check("reset_outputs", pulses(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_state", 32'(db_estado), 0);
        check("idle_outputs", pulses(), 0);

        start_run();
        do_round(10, 20, 30, -1, 5);
        enter_wait();

        d = int'($urandom_range(0, 40));
        do_round(d, d, d, 4, 0);

        start_run();
        for (int r = 0; r < 4; r++) begin
            stop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
            do_round(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 40)), stop, 0);
            if (ligar) enter_wait();
            else start_run();
        end

        pronto_medida1 = 1'b1; pronto_medida2 = 1'b1; pronto_medida3 = 1'b1;
        @(negedge clock);
        pronto_medida1 = 1'b0; pronto_medida2 = 1'b0; pronto_medida3 = 1'b0;
        check("simul_tx_state", 32'(db_estado), 4);
        check("simul_erro", 32'(erro_medida), 0);
        @(negedge clock);
        check("pre_reset_state", 32'(db_estado), 5);
        #2 reset = 1'b0;
        #1;
        check("async_reset_state", 32'(db_estado), 0);
        check("async_reset_sel", 32'({sel_sensor, sel_digito}), 32'h0000_000F);
        check("async_reset_outputs", pulses(), 0);
        @(negedge clock);
        reset = 1'b1;
        start_run();

`ifdef ROBERTO_UC_TIMEOUT_EN
        do_round(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, -1, 0);
        enter_wait();
        do_round(T - 1, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, 0);
`else
        do_round(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, -1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/roberto_uc.md
# roberto_uc

Control unit for the three-sensor distance datapath. Sequences each round: trigger a simultaneous measurement on all three HC-SR04 interfaces, wait for completion, then stream 12 ASCII characters (hundreds, tens, units, '#' per sensor) through the 7E1 serial transmitter by driving the datapath's digit and sensor mux selects. Between rounds it waits one second on the datapath's seconds counter. It sits directly upstream of the datapath: every enable, clear and select there comes from this block.

## Interface
- `TIMEOUT_CICLOS`, default 5_000_000: measurement timeout in clock cycles, 100 ms at 50 MHz.
- `N_TIMEOUT`, default 23: width of the timeout counter; must satisfy 2^N_TIMEOUT > TIMEOUT_CICLOS.

- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `ligar` in 1: run enable, level-sensitive.
- `pronto_medida1`, `pronto_medida2`, `pronto_medida3` in 1: per-sensor measurement-done pulses.
- `pronto_serial` in 1: transmitter finished current character.
- `pronto_seg` in 1: seconds counter reached its end.
- `zera_sensor`, `zera_serial`, `zera_seg` out 1: synchronous clears to the datapath.
- `medir` out 1: start-measurement pulse to all three sensors.
- `cont_seg` out 1: seconds-counter enable.
- `partida_tx` out 1: transmit-start pulse.
- `sel_digito` out 2: character select. 3 = hundreds, 2 = tens, 1 = units, 0 = '#'.
- `sel_sensor` out 2: sensor select. 3 = sensor 1, 2 = sensor 2, 1 = sensor 3. Value 0 is never driven outside reset paths.
- `pronto` out 1: one-cycle pulse when a round's 12th character completes.
- `erro_medida` out 1: sticky flag meaning the last measurement timed out.
- `db_estado` out 4: current state encoding.

## Operation
- States and encodings:
  - inicial=0
  - preparacao=1
  - medida=2
  - espera_medida=3
  - transmite=4
  - espera_tx=5
  - proximo=6
  - espera_seg=7
  - Unused encodings go to inicial.
- **inicial**
  - All outputs are 0.
  - `sel_digito` and `sel_sensor` are both 3.
  - Goes to preparacao when `ligar`=1.
- **preparacao**
  - `zera_sensor`, `zera_serial` and `zera_seg` are 1 for one cycle.
  - Goes to medida.
- **medida**
  - `medir`=1 and `zera_seg`=1.
  - Clears the three done-latches, the timeout counter and `erro_medida`.
  - Loads `sel_sensor`=3 and `sel_digito`=3.
  - Goes to espera_medida.
- **espera_medida**
  - Each `pronto_medidaX` pulse sets its latch. The latch test includes the current-cycle input.
  - When all three latches are set, goes to transmite.
  - When the timeout counter reaches `TIMEOUT_CICLOS`-1, sets `erro_medida` and goes to transmite. Stale measurement values are sent.
  - If completion and timeout occur in the same cycle, completion wins and `erro_medida` stays 0.
- **transmite**: `partida_tx`=1 for one cycle, then goes to espera_tx.
- **espera_tx**: waits for `pronto_serial`, then goes to proximo.
- **proximo**
  - If `sel_sensor`=1 and `sel_digito`=0, asserts `pronto` and goes to espera_seg.
  - Otherwise, if `sel_digito`=0, sets `sel_digito`=3 and decrements `sel_sensor`; if not, decrements `sel_digito`. Then goes to transmite.
- **espera_seg**
  - `cont_seg`=1.
  - On `pronto_seg`: goes to medida if `ligar`=1, else inicial.
- `ligar` is sampled only in inicial and espera_seg. Deasserting it mid-round lets the round finish.
- Character order per round:
  - sensor 1: D3, D2, D1, '#'
  - sensor 2: D3, D2, D1, '#'
  - sensor 3: D3, D2, D1, '#'

## Timing
- Reset (`reset`=0, asynchronous): state inicial, selects 3/3, latches and counters 0, all other outputs 0.
- State outputs are Moore-decoded from the state register.
- `medir`, `partida_tx` and `pronto` are each exactly one cycle wide.
- From `ligar` rising in inicial at edge k:
  - preparacao at k+1
  - medida at k+2 (`medir` high during k+2 to k+3)
- From the last `pronto_medidaX` sampled at edge m: `partida_tx` high in the cycle after edge m+1.
- From `pronto_serial` at edge t: proximo at t+1, next `partida_tx` at t+2.
- Selects are stable for the whole of transmite and espera_tx.
- Timeout path: entering espera_medida at edge e with no done pulses gives `erro_medida`=1 and transmite at edge e+`TIMEOUT_CICLOS`.

## Configuration
- `ROBERTO_UC_TIMEOUT_EN`
  - Defined: timeout counter and `erro_medida` are implemented as above.
  - Undefined: espera_medida waits indefinitely for all three latches, `erro_medida` is tied to 0, and no counter logic is generated.

## Test plan
- **Reset:** `reset`=0 mid-espera_tx -> `db_estado`=0, `sel_digito`=3, `sel_sensor`=3, all pulses 0, on the same clock edge without waiting.
- **Full round:** `ligar`=1; done pulses at +10, +20, +30 cycles; `pronto_serial` 5 cycles after each `partida_tx` -> exactly 12 `partida_tx` pulses; select pairs (3,3),(3,2),(3,1),(3,0),(2,3),…,(1,0); one `pronto` pulse; then `cont_seg`=1.
- **Simultaneous completion:** all three `pronto_medida` pulses in the same cycle -> transmite on the next edge, `erro_medida`=0.
- **Timeout:** `TIMEOUT_CICLOS`=100, only sensors 1 and 2 respond -> `erro_medida`=1 and `partida_tx` 100 cycles after entering espera_medida. Without the macro, the block stays in state 3 indefinitely.
- **Stop:** `ligar`=0 during transmission of character 5 -> all 12 characters are still sent; after `pronto_seg`, `db_estado`=0. With `ligar`=1 at `pronto_seg`, the next cycle is medida with `medir`=1.
